// File: rtl/spi_engine.sv
// -----------------------------------------------------------------------------
// spi_engine
// Byte-oriented SPI master for the Gigatron extension CPLD. Software writes a
// byte to DATA; the engine shifts 8 bits out on MOSI and in from MISO at a
// programmable half-bit period, in any of the four SPI modes, then sets DONE.
//
// Optional feature macro: SPI_ENGINE_TXBUF_EN
//   Defined     -> one-byte transmit holding buffer, back-to-back transfers.
//   Not defined -> no buffer; any DATA write while busy is an overrun.
//
// Parameters:
//   NSS   number of slave-select outputs (1..8)
//   DIVW  width of the clock divider register (1..8)
//
// Ports:
//   CLK     in   clock, rising edge
//   nRESET  in   asynchronous active-low reset
//   WR      in   one-cycle register write strobe
//   WADDR   in   [1:0] write register select (0 DATA, 1 CTRL, 2 DIV, 3 STATUS)
//   WDATA   in   [7:0] write data
//   RADDR   in   [1:0] read register select
//   RDATA   out  [7:0] combinational read data
//   MISO    in   [NSS:0] serial inputs; MISO[NSS] used when no slave selected
//   MOSI    out  serial output
//   SCK     out  serial clock
//   nSS     out  [NSS-1:0] active-low slave selects
//   BUSY    out  transfer in progress
// -----------------------------------------------------------------------------
module spi_engine #(
    parameter int NSS  = 2,
    parameter int DIVW = 4
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic            WR,
    input  logic [1:0]      WADDR,
    input  logic [7:0]      WDATA,
    input  logic [1:0]      RADDR,
    output logic [7:0]      RDATA,
    input  logic [NSS:0]    MISO,
    output logic            MOSI,
    output logic            SCK,
    output logic [NSS-1:0]  nSS,
    output logic            BUSY
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_CTRL = 2'd1;
    localparam logic [1:0] A_DIV  = 2'd2;
    localparam logic [1:0] A_STAT = 2'd3;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [7:0]        r_ctrl;        // [7:4] SS, [2] LSBF, [1] CPOL, [0] CPHA
    logic [DIVW-1:0]   r_div;
    logic [7:0]        r_rx_data;
    logic              r_done;
    logic              r_ovr;

    // Transfer-local copies, latched at load so the shifter is self-contained.
    logic              r_cpha;
    logic              r_cpol;
    logic              r_lsbf;
    logic [DIVW-1:0]   r_div_l;
    logic [DIVW-1:0]   r_divcnt;
    logic [3:0]        r_phase;
    logic [7:0]        r_tx_sh;
    logic [7:0]        r_rx_sh;
    logic              r_sck;
    logic              r_mosi;

    logic              w_busy;
    logic              w_wr_data;
    logic              w_wr_ctrl;
    logic              w_wr_div;
    logic              w_wr_stat;
    logic              w_tc;
    logic [3:0]        w_phase_nxt;
    logic              w_lead;
    logic              w_trail;
    logic              w_last;
    logic              w_sample;
    logic              w_shift;
    logic              w_miso;
    logic [3:0]        w_ss;
    logic [7:0]        w_rx_next;
    logic              w_start_idle;
    logic              w_chain;
    logic [7:0]        w_chain_data;
    logic              w_load;
    logic [7:0]        w_load_data;
    logic              w_ovr_data;
    logic              w_ovr_set;
    logic              w_txfull;

    function automatic logic f_first(input logic [7:0] d, input logic lsbf);
        return lsbf ? d[0] : d[7];
    endfunction

    function automatic logic [7:0] f_shift(input logic [7:0] d, input logic lsbf);
        return lsbf ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
    endfunction

    assign w_busy    = (r_state == ST_SHIFT);
    assign w_wr_data = WR && (WADDR == A_DATA);
    assign w_wr_ctrl = WR && (WADDR == A_CTRL);
    assign w_wr_div  = WR && (WADDR == A_DIV);
    assign w_wr_stat = WR && (WADDR == A_STAT);

    // Phase numbering: phase N is the state after the Nth SCK edge, 1..16.
    // Odd N = leading edge, even N = trailing edge; the 4-bit counter wraps
    // to 0 on the 16th edge, which is still even (trailing).
    assign w_tc        = w_busy && (r_divcnt == r_div_l);
    assign w_phase_nxt = r_phase + 4'd1;
    assign w_lead      = w_tc && w_phase_nxt[0];
    assign w_trail     = w_tc && !w_phase_nxt[0];
    assign w_last      = w_tc && (r_phase == 4'd15);
    assign w_sample    = r_cpha ? w_trail : w_lead;
    // CPHA=0 drives its first bit at load, so the final trailing edge must not
    // shift again; MOSI then holds the last bit.
    assign w_shift     = r_cpha ? w_lead : (w_trail && !w_last);

    assign w_ss = r_ctrl[7:4];

    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nSS    = '1;
        w_miso = MISO[NSS];
        for (int i = 0; i < NSS; i++) begin
            if (w_ss == 4'(i)) begin
                nSS[i] = 1'b0;
                w_miso = MISO[i];
            end
        end
    end

    assign w_rx_next = !w_sample ? r_rx_sh :
                       r_lsbf    ? {w_miso, r_rx_sh[7:1]} :
                                   {r_rx_sh[6:0], w_miso};

    assign w_start_idle = w_wr_data && !w_busy;

`ifdef SPI_ENGINE_TXBUF_EN
    logic       r_txfull;
    logic [7:0] r_txbuf;
    logic       w_buf_wr;

    // A write landing on the final edge with an empty buffer goes straight
    // into the shifter instead of through the buffer.
    assign w_chain      = w_last && (r_txfull || w_wr_data);
    assign w_chain_data = r_txfull ? r_txbuf : WDATA;
    assign w_ovr_data   = w_wr_data && w_busy && r_txfull;
    assign w_buf_wr     = w_wr_data && w_busy && !r_txfull && !w_last;
    assign w_txfull     = r_txfull;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_txfull <= 1'b0;
            r_txbuf  <= 8'h00;
        end else if (w_buf_wr) begin
            r_txfull <= 1'b1;
            r_txbuf  <= WDATA;
        end else if (w_last && r_txfull) begin
            r_txfull <= 1'b0;
        end
    end
`else
    assign w_chain      = 1'b0;
    assign w_chain_data = WDATA;
    assign w_ovr_data   = w_wr_data && w_busy;
    assign w_txfull     = 1'b0;
`endif

    assign w_load      = w_start_idle || w_chain;
    assign w_load_data = w_start_idle ? WDATA : w_chain_data;
    assign w_ovr_set   = w_ovr_data || (w_busy && (w_wr_ctrl || w_wr_div));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_idle)        w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last && !w_chain)  w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    // NOTE: sequential state uses non-blocking assignments only; later
    // assignments in this block deliberately override earlier ones (a load
    // on the final edge replaces the edge update of the shifter).
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_ctrl    <= 8'hF0;
            r_div     <= '1;
            r_rx_data <= 8'h00;
            r_done    <= 1'b0;
            r_ovr     <= 1'b0;
            r_cpha    <= 1'b0;
            r_cpol    <= 1'b0;
            r_lsbf    <= 1'b0;
            r_div_l   <= '0;
            r_divcnt  <= '0;
            r_phase   <= 4'd0;
            r_tx_sh   <= 8'h00;
            r_rx_sh   <= 8'h00;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            if (w_busy) begin
                if (w_tc) begin
                    r_divcnt <= '0;
                    r_phase  <= w_phase_nxt;
                    r_sck    <= ~r_sck;
                    r_rx_sh  <= w_rx_next;
                    if (w_shift) begin
                        r_mosi  <= f_first(r_tx_sh, r_lsbf);
                        r_tx_sh <= f_shift(r_tx_sh, r_lsbf);
                    end
                end else begin
                    r_divcnt <= r_divcnt + 1'b1;
                end
            end

            if (w_last) r_rx_data <= w_rx_next;

            if (w_load) begin
                r_cpha   <= r_ctrl[0];
                r_cpol   <= r_ctrl[1];
                r_lsbf   <= r_ctrl[2];
                r_div_l  <= r_div;
                r_divcnt <= '0;
                r_phase  <= 4'd0;
                r_rx_sh  <= 8'h00;
                r_sck    <= r_ctrl[1];
                if (r_ctrl[0]) begin
                    r_tx_sh <= w_load_data;
                end else begin
                    r_mosi  <= f_first(w_load_data, r_ctrl[2]);
                    r_tx_sh <= f_shift(w_load_data, r_ctrl[2]);
                end
            end

            if (w_wr_ctrl && !w_busy) r_ctrl <= {WDATA[7:4], 1'b0, WDATA[2:0]};
            if (w_wr_div && !w_busy)  r_div  <= WDATA[DIVW-1:0];

            // A completing transfer sets DONE even if software clears it in
            // the same cycle; an idle-start clears it.
            if (w_last)                        r_done <= 1'b1;
            else if (w_start_idle)             r_done <= 1'b0;
            else if (w_wr_stat && WDATA[1])    r_done <= 1'b0;

            if (w_ovr_set)                     r_ovr <= 1'b1;
            else if (w_wr_stat && WDATA[2])    r_ovr <= 1'b0;
        end
    end

    // ------------------------------------------------------------- outputs
    assign BUSY = w_busy;
    assign MOSI = r_mosi;
    // Idle SCK tracks CTRL.CPOL directly so a mode change shows at once.
    assign SCK  = w_busy ? r_sck : r_ctrl[1];

    always_comb begin
        RDATA = 8'h00;
        case (RADDR)
            A_DATA:  RDATA = r_rx_data;
            A_CTRL:  RDATA = r_ctrl;
            A_DIV:   RDATA[DIVW-1:0] = r_div;
            A_STAT:  RDATA = {4'b0000, w_txfull, r_ovr, r_done, w_busy};
            default: RDATA = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spi_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_engine
// Directed self-checking bench for spi_engine (NSS=2, DIVW=4). A behavioural
// SPI slave inside the watch task drives MISO and captures MOSI on the slave's
// sample edges while counting BUSY cycles and SCK edge spacing.
// -----------------------------------------------------------------------------
module tb_spi_engine;

    localparam int NSS  = 2;
    localparam int DIVW = 4;

    logic           CLK = 1'b0;
    logic           nRESET;
    logic           WR;
    logic [1:0]     WADDR;
    logic [7:0]     WDATA;
    logic [1:0]     RADDR;
    logic [7:0]     RDATA;
    logic [NSS:0]   MISO;
    logic           MOSI;
    logic           SCK;
    logic [NSS-1:0] nSS;
    logic           BUSY;

    int n_checks = 0;
    int n_errors = 0;

    logic [NSS:0] sl_lines;     // MISO lines that carry the slave's data
    int           busy_cyc;
    int           edges;
    int           first_edge;
    logic         spacing_ok;
    logic         timeout;
    logic [15:0]  cap;
    logic         p_sck;

    always #5 CLK = ~CLK;

    spi_engine #(.NSS(NSS), .DIVW(DIVW)) dut (
        .CLK    (CLK),
        .nRESET (nRESET),
        .WR     (WR),
        .WADDR  (WADDR),
        .WDATA  (WDATA),
        .RADDR  (RADDR),
        .RDATA  (RDATA),
        .MISO   (MISO),
        .MOSI   (MOSI),
        .SCK    (SCK),
        .nSS    (nSS),
        .BUSY   (BUSY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        WR    = 1'b1;
        WADDR = a;
        WDATA = d;
        @(negedge CLK);
        WR    = 1'b0;
    endtask

    task automatic rd_check(input logic [1:0] a, input logic [7:0] e, input string tag);
        RADDR = a;
        #1;
        check(tag, {24'h0, RDATA}, {24'h0, e});
    endtask

    // Slave + monitor. Enter at the falling edge of cycle 'start' (cycle 1 is
    // the first BUSY cycle); cycles before 'start' are counted as busy.
    task automatic watch(input logic cpha, input logic lsbf, input logic [7:0] sl,
                         input int div, input int start, input logic prev_in,
                         output int o_busy, output int o_edges, output int o_first,
                         output logic o_spacing, output logic o_timeout,
                         output logic [15:0] o_cap);
        int   cyc;
        int   idx;
        int   last_edge;
        int   j;
        logic prev;
        logic fin;
        logic b;
        cyc = start; o_busy = start - 1; o_edges = 0; o_first = 0;
        o_spacing = 1'b1; o_timeout = 1'b0; o_cap = 16'h0000;
        last_edge = 0; prev = prev_in; fin = 1'b0; idx = 0;
        if (!cpha) begin
            b = lsbf ? sl[0] : sl[7];
            MISO = b ? sl_lines : '0;
            idx = 1;
        end
        while (!fin) begin
            if (SCK !== prev) begin
                o_edges++;
                prev = SCK;
                if (o_edges == 1) o_first = cyc;
                else if (cyc - last_edge != div + 1) o_spacing = 1'b0;
                last_edge = cyc;
                if ((o_edges % 2 == 1) != cpha) begin
                    o_cap = {o_cap[14:0], MOSI};
                end else begin
                    j = idx % 8;
                    b = lsbf ? sl[j] : sl[7 - j];
                    MISO = b ? sl_lines : '0;
                    idx++;
                end
            end
            if (BUSY !== 1'b1) begin
                fin = 1'b1;
            end else begin
                o_busy++;
                if (cyc > 3000) begin
                    o_timeout = 1'b1;
                    fin = 1'b1;
                end else begin
                    @(negedge CLK);
                    cyc++;
                end
            end
        end
    endtask

    initial begin
        nRESET = 1'b0; WR = 1'b0; WADDR = 2'd0; WDATA = 8'h00; RADDR = 2'd0;
        MISO = '0; sl_lines = '0;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);

        // ---------------- reset state
        check("rst_sck",  {31'h0, SCK},  32'h0);
        check("rst_mosi", {31'h0, MOSI}, 32'h0);
        check("rst_busy", {31'h0, BUSY}, 32'h0);
        check("rst_nss",  {30'h0, nSS},  32'h3);
        rd_check(2'd0, 8'h00, "rst_data");
        rd_check(2'd1, 8'hF0, "rst_ctrl");
        @(negedge CLK);
        rd_check(2'd2, 8'h0F, "rst_div");
        rd_check(2'd3, 8'h00, "rst_status");
        @(negedge CLK);

        // ---------------- mode 0, DIV=0, SS=0, 0xA5 out, 0x3C back
        wr(2'd1, 8'h00);
        check("m0_nss", {30'h0, nSS}, 32'h2);
        wr(2'd2, 8'h00);
        sl_lines = 3'b001;
        p_sck = SCK;
        wr(2'd0, 8'hA5);
        check("m0_busy_rise", {31'h0, BUSY}, 32'h1);
        watch(1'b0, 1'b0, 8'h3C, 0, 1, p_sck, busy_cyc, edges, first_edge, spacing_ok, timeout, cap);
        check("m0_timeout", {31'h0, timeout}, 32'h0);
        rd_check(2'd3, 8'h02, "m0_status_done");
        rd_check(2'd0, 8'h3C, "m0_rx");
        check("m0_busy_cycles", busy_cyc, 32'd16);
        check("m0_edges",       edges, 32'd16);
        check("m0_first_edge",  first_edge, 32'd2);
        check("m0_spacing",     {31'h0, spacing_ok}, 32'h1);
        check("m0_mosi_bits",   {16'h0, cap}, 32'h00A5);
        check("m0_sck_idle",    {31'h0, SCK}, 32'h0);
        @(negedge CLK);
        wr(2'd3, 8'h02);
        rd_check(2'd3, 8'h00, "m0_done_clear");
        @(negedge CLK);

        // ---------------- mode 3, LSBF, DIV=2, 0x81 out, 0x5A back
        wr(2'd1, 8'h07);
        check("m3_sck_idle_high", {31'h0, SCK}, 32'h1);
        wr(2'd2, 8'h02);
        p_sck = SCK;
        wr(2'd0, 8'h81);
        watch(1'b1, 1'b1, 8'h5A, 2, 1, p_sck, busy_cyc, edges, first_edge, spacing_ok, timeout, cap);
        check("m3_timeout", {31'h0, timeout}, 32'h0);
        check("m3_busy_cycles", busy_cyc, 32'd48);
        check("m3_edges",       edges, 32'd16);
        check("m3_first_edge",  first_edge, 32'd4);
        check("m3_spacing",     {31'h0, spacing_ok}, 32'h1);
        check("m3_mosi_bits",   {16'h0, cap}, 32'h0081);
        check("m3_sck_end",     {31'h0, SCK}, 32'h1);
        rd_check(2'd0, 8'h5A, "m3_rx");
        @(negedge CLK);

        // ---------------- SS=NSS routes MISO[NSS]; CTRL write while busy
        wr(2'd2, 8'h03);
        wr(2'd1, 8'h20);
        check("ssn_nss", {30'h0, nSS}, 32'h3);
        sl_lines = 3'b100;
        p_sck = SCK;
        wr(2'd0, 8'h00);
        wr(2'd1, 8'h00);
        rd_check(2'd1, 8'h20, "busy_ctrl_kept");
        rd_check(2'd3, 8'h05, "busy_ctrl_ovr");
        watch(1'b0, 1'b0, 8'hFF, 3, 2, p_sck, busy_cyc, edges, first_edge, spacing_ok, timeout, cap);
        check("ssn_timeout", {31'h0, timeout}, 32'h0);
        check("ssn_busy_cycles", busy_cyc, 32'd64);
        check("ssn_first_edge",  first_edge, 32'd5);
        rd_check(2'd0, 8'hFF, "ssn_rx");
        rd_check(2'd3, 8'h06, "ssn_status");
        @(negedge CLK);
        wr(2'd3, 8'h06);
        rd_check(2'd3, 8'h00, "ovr_clear");
        @(negedge CLK);

        // ---------------- overrun / holding buffer, mode 0, DIV=1
        wr(2'd1, 8'h00);
        wr(2'd2, 8'h01);
        sl_lines = 3'b000;
        p_sck = SCK;
        WR = 1'b1; WADDR = 2'd0; WDATA = 8'hC3;
        @(negedge CLK);
        WDATA = 8'h5A;
        @(negedge CLK);
`ifdef SPI_ENGINE_TXBUF_EN
        rd_check(2'd3, 8'h09, "buf_txfull");
        WDATA = 8'h0F;
        @(negedge CLK);
        WR = 1'b0;
        rd_check(2'd3, 8'h0D, "buf_ovr");
`else
        WR = 1'b0;
        rd_check(2'd3, 8'h05, "nobuf_ovr");
        @(negedge CLK);
`endif
        watch(1'b0, 1'b0, 8'h00, 1, 3, p_sck, busy_cyc, edges, first_edge, spacing_ok, timeout, cap);
        check("ovr_timeout", {31'h0, timeout}, 32'h0);
        check("ovr_first_edge", first_edge, 32'd3);
        check("ovr_spacing", {31'h0, spacing_ok}, 32'h1);
`ifdef SPI_ENGINE_TXBUF_EN
        check("buf_busy_cycles", busy_cyc, 32'd64);
        check("buf_edges",       edges, 32'd32);
        check("buf_mosi_bits",   {16'h0, cap}, 32'hC35A);
`else
        check("nobuf_busy_cycles", busy_cyc, 32'd32);
        check("nobuf_edges",       edges, 32'd16);
        check("nobuf_mosi_bits",   {16'h0, cap}, 32'h00C3);
`endif
        rd_check(2'd3, 8'h06, "ovr_status_end");
        @(negedge CLK);

        // ---------------- reset mid-transfer, CPOL=1, DIV=3
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h03);
        wr(2'd0, 8'h55);
        repeat (6) @(negedge CLK);
        check("mid_busy_before", {31'h0, BUSY}, 32'h1);
        RADDR = 2'd3;
        nRESET = 1'b0;
        #1;
        check("mid_rst_sck",    {31'h0, SCK},  32'h0);
        check("mid_rst_nss",    {30'h0, nSS},  32'h3);
        check("mid_rst_busy",   {31'h0, BUSY}, 32'h0);
        check("mid_rst_mosi",   {31'h0, MOSI}, 32'h0);
        check("mid_rst_status", {24'h0, RDATA}, 32'h00);
        @(negedge CLK);
        nRESET = 1'b1;
        rd_check(2'd1, 8'hF0, "mid_rst_ctrl");
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
